// File: rtl/pix_sdram_writer_pkg.sv
// -----------------------------------------------------------------------------
// pix_sdram_writer_pkg
// Shared definitions for the pixel-to-SDRAM frame writer and the SDRAM
// controller top: bus widths and the writer state encoding.
// -----------------------------------------------------------------------------
package pix_sdram_writer_pkg;

    localparam int SdramAddrWidth  = 23;   // SDRAM word-address width
    localparam int SdramDataWidth  = 16;   // SDRAM word width
    localparam int SdramPixelWidth = 12;   // pixel width from the pixel FIFO

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2
    } wr_state_e;

endpackage : pix_sdram_writer_pkg

// File: rtl/pix_sdram_writer_if.sv
// -----------------------------------------------------------------------------
// pix_sdram_writer_if
// Bundles the pixel-FIFO read side and the SDRAM command side seen by the
// frame writer.
//   fifo_q / fifo_qValid / fifo_qout           : FIFO head, valid, pop request
//   cmdReady / cmdTrigger / cmdAddr /
//   cmdWrite / cmdWriteData                     : SDRAM command handshake
// master = frame writer, slave = FIFO + SDRAM controller side.
// -----------------------------------------------------------------------------
interface pix_sdram_writer_if
    import pix_sdram_writer_pkg::*;
#(
    parameter int AddrWidth  = SdramAddrWidth,
    parameter int DataWidth  = SdramDataWidth,
    parameter int PixelWidth = SdramPixelWidth
);

    logic [PixelWidth-1:0] fifo_q;
    logic                  fifo_qValid;
    logic                  fifo_qout;
    logic                  cmdReady;
    logic                  cmdTrigger;
    logic [AddrWidth-1:0]  cmdAddr;
    logic                  cmdWrite;
    logic [DataWidth-1:0]  cmdWriteData;

    modport master (
        input  fifo_q,
        input  fifo_qValid,
        input  cmdReady,
        output fifo_qout,
        output cmdTrigger,
        output cmdAddr,
        output cmdWrite,
        output cmdWriteData
    );

    modport slave (
        output fifo_q,
        output fifo_qValid,
        output cmdReady,
        input  fifo_qout,
        input  cmdTrigger,
        input  cmdAddr,
        input  cmdWrite,
        input  cmdWriteData
    );

endinterface : pix_sdram_writer_if

// File: rtl/pix_sdram_writer.sv
// -----------------------------------------------------------------------------
// pix_sdram_writer
// Moves one frame of PixelCount pixels from the pixel FIFO into SDRAM as
// single-word writes at BaseAddr, BaseAddr+1, ... One pixel is popped into a
// holding register per cycle while the controller keeps accepting, giving one
// word per cycle back-to-back.
//
// Ports
//   clk    : SDRAM controller clock
//   rst_   : asynchronous active-low reset
//   start  : one-cycle pulse arming one frame (ignored while busy)
//   bus    : master side of pix_sdram_writer_if (FIFO pop + SDRAM command)
//   busy   : frame in progress (Write or Drain)
//   done   : one-cycle pulse after the last word of the frame is accepted
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, FIFO untouched
// ST_WRITE | popping pixels and issuing writes
// ST_DRAIN | all pixels popped, waiting for the last write to be accepted
// -----------------------------------------------------------------------------
module pix_sdram_writer
    import pix_sdram_writer_pkg::*;
#(
    parameter int AddrWidth  = SdramAddrWidth,
    parameter int DataWidth  = SdramDataWidth,
    parameter int PixelWidth = SdramPixelWidth,
    parameter int PixelCount = 2985984,
    parameter int BaseAddr   = 0
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      start,
    pix_sdram_writer_if.master        bus,
    output logic                      busy,
    output logic                      done
);

    localparam int                    CntWidth   = $clog2(PixelCount + 1);
    localparam logic [CntWidth-1:0]   CntFull    = CntWidth'(PixelCount);
    localparam logic [CntWidth-1:0]   CntLast    = CntWidth'(PixelCount - 1);
    localparam logic [AddrWidth-1:0]  FirstAddr  = AddrWidth'(BaseAddr);

    // A frame must fit below 2^AddrWidth so the address can never wrap.
    if ((longint'(BaseAddr) + longint'(PixelCount)) > (longint'(1) << AddrWidth)) begin : g_addr_range_err
        $error("pix_sdram_writer: BaseAddr+PixelCount exceeds the address space");
    end
    if (DataWidth < PixelWidth) begin : g_width_err
        $error("pix_sdram_writer: DataWidth narrower than PixelWidth");
    end

    wr_state_e              r_state;
    wr_state_e              w_next_state;
    logic [CntWidth-1:0]    r_popped;
    logic [AddrWidth-1:0]   r_cmd_addr;
    logic [DataWidth-1:0]   r_cmd_data;
    logic                   r_cmd_trig;
    logic                   r_done;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_busy;
    logic                   w_done_set;

    assign w_accept = r_cmd_trig & bus.cmdReady;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_busy       = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_busy = 1'b1;
                // Pop only when the holding register is free or is being
                // emptied on this same edge.
                w_pop  = bus.fifo_qValid && (!r_cmd_trig || bus.cmdReady) &&
                         (r_popped < CntFull);
                if (w_pop && (r_popped == CntLast)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_accept) begin
                    w_next_state = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_popped   <= '0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
            r_cmd_trig <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_popped   <= '0;
                    r_cmd_addr <= FirstAddr;
                end
            end else begin
                // The word accepted in Drain is the last one, so the address
                // stops at BaseAddr+PixelCount-1.
                if (w_accept && (r_state == ST_WRITE)) begin
                    r_cmd_addr <= r_cmd_addr + 1'b1;
                end
                if (w_pop) begin
                    r_cmd_data <= DataWidth'(bus.fifo_q);
                    r_cmd_trig <= 1'b1;
                    r_popped   <= r_popped + 1'b1;
                end else if (w_accept) begin
                    r_cmd_trig <= 1'b0;
                end
            end
        end
    end

    assign bus.fifo_qout    = w_pop;
    assign bus.cmdTrigger   = r_cmd_trig;
    assign bus.cmdAddr      = r_cmd_addr;
    assign bus.cmdWrite     = 1'b1;
    assign bus.cmdWriteData = r_cmd_data;
    assign busy             = w_busy;
    assign done             = r_done;

endmodule : pix_sdram_writer

// File: tb/tb_pix_sdram_writer.sv
module tb_pix_sdram_writer;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_;
    logic start;
    logic busy;
    logic done;

    pix_sdram_writer_if bus ();

    pix_sdram_writer #(
        .PixelCount (4),
        .BaseAddr   ('h100)
    ) u_dut (
        .clk   (clk),
        .rst_  (rst_),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // ---------------- pixel FIFO model ----------------
    logic [11:0] fmem [0:127];
    logic [6:0]  wr_ptr = '0;
    logic [6:0]  rd_ptr = '0;
    logic        valid_en = 1'b0;
    logic [6:0]  level;

    assign level           = wr_ptr - rd_ptr;
    assign bus.fifo_q      = fmem[rd_ptr];
    assign bus.fifo_qValid = valid_en && (rd_ptr != wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_qout && bus.fifo_qValid) rd_ptr <= rd_ptr + 7'd1;
    end

    // ---------------- bookkeeping ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   frame_acc = 0;
    int   frame_pop = 0;
    int   first_acc_cyc = 0;
    int   last_acc_cyc = 0;
    logic exp_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        if (rst_) begin
            cyc++;
            chk("done_timing", {31'd0, done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (done) done_cnt++;
            if (bus.fifo_qout) begin
                frame_pop++;
                chk("pop_needs_valid", {31'd0, bus.fifo_qValid}, 32'd1);
            end
            if (bus.cmdTrigger) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd_addr", {9'd0, bus.cmdAddr}, 32'hFFFF_FFFF);
                end else begin
                    chk("cmd_addr", {9'd0, bus.cmdAddr}, {9'd0, sb[0].addr});
                    chk("cmd_data", {16'd0, bus.cmdWriteData}, {16'd0, sb[0].data});
                    if (bus.cmdReady) begin
                        void'(sb.pop_front());
                        if (frame_acc == 0) first_acc_cyc = cyc;
                        last_acc_cyc = cyc;
                        frame_acc++;
                        if (sb.size() == 0) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr] = first + 12'(i);
            wr_ptr = wr_ptr + 7'd1;
        end
    endtask

    task automatic push_frame(input logic [11:0] first_pix);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.addr = 23'h100 + 23'(i);
            e.data = {4'h0, first_pix + 12'(i)};
            sb.push_back(e);
        end
        frame_acc = 0;
        frame_pop = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic toggle);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (toggle) valid_en = ~valid_en;
            tick();
            if (done_cnt != d0) break;
        end
        valid_en = 1'b1;
        chk(tag, done_cnt - d0, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int k;
        for (int i = 0; i < 128; i++) fmem[i] = '0;
        rst_         = 1'b0;
        start        = 1'b0;
        bus.cmdReady = 1'b1;
        repeat (3) tick();

        chk("rst_trig",  {31'd0, bus.cmdTrigger}, 32'd0);
        chk("rst_addr",  {9'd0, bus.cmdAddr}, 32'd0);
        chk("rst_data",  {16'd0, bus.cmdWriteData}, 32'd0);
        chk("rst_write", {31'd0, bus.cmdWrite}, 32'd1);
        chk("rst_pop",   {31'd0, bus.fifo_qout}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);

        // Idle with a full FIFO must not pop.
        preload(12'hA01, 4);
        valid_en = 1'b1;
        tick();
        rst_ = 1'b1;
        repeat (3) tick();
        chk("idle_no_pop", {31'd0, bus.fifo_qout}, 32'd0);
        chk("idle_level",  {25'd0, level}, 32'd4);

        // Frame 1: back-to-back, cmdReady always high.
        push_frame(12'hA01);
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done", 30, 1'b0);
        tick();
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_span",       last_acc_cyc - first_acc_cyc, 32'd3);
        chk("t1_acc",        frame_acc, 32'd4);
        chk("t1_last_addr",  {9'd0, bus.cmdAddr}, 32'h103);
        chk("t1_trig_clear", {31'd0, bus.cmdTrigger}, 32'd0);
        chk("t1_level",      {25'd0, level}, 32'd0);

        // Frame 2: controller stalls the first word for 3 cycles.
        bus.cmdReady = 1'b0;
        preload(12'hB01, 4);
        push_frame(12'hB01);
        pulse_start();
        k = 0;
        while (!bus.cmdTrigger && k < 10) begin tick(); k++; end
        chk("t2_trig_seen", {31'd0, bus.cmdTrigger}, 32'd1);
        chk("t2_one_pop",   frame_pop, 32'd1);
        repeat (3) tick();
        chk("t2_trig_hold", {31'd0, bus.cmdTrigger}, 32'd1);
        chk("t2_no_pop",    frame_pop, 32'd1);
        chk("t2_addr_hold", {9'd0, bus.cmdAddr}, 32'h100);
        chk("t2_data_hold", {16'd0, bus.cmdWriteData}, 32'h0B01);
        bus.cmdReady = 1'b1;
        wait_done("t2_done", 30, 1'b0);
        chk("t2_acc", frame_acc, 32'd4);

        // Frame 3: FIFO valid toggling every cycle.
        preload(12'hE01, 4);
        push_frame(12'hE01);
        pulse_start();
        wait_done("t3_done", 60, 1'b1);
        chk("t3_pops", frame_pop, 32'd4);
        chk("t3_acc",  frame_acc, 32'd4);

        // Frame 4: start re-pulsed mid-frame.
        preload(12'hF01, 4);
        push_frame(12'hF01);
        d0 = done_cnt;
        pulse_start();
        k = 0;
        while (frame_acc < 1 && k < 30) begin valid_en = ~valid_en; tick(); k++; end
        chk("t4_first_acc", frame_acc, 32'd1);
        pulse_start();
        wait_done("t4_done", 60, 1'b1);
        repeat (5) tick();
        chk("t4_single_done", done_cnt - d0, 32'd1);
        chk("t4_acc",         frame_acc, 32'd4);
        chk("t4_idle",        {31'd0, busy}, 32'd0);

        // Frame 5: reset after the 2nd accepted write.
        preload(12'hC01, 4);
        push_frame(12'hC01);
        d0 = done_cnt;
        pulse_start();
        k = 0;
        while (frame_acc < 2 && k < 20) begin tick(); k++; end
        chk("t5_two_acc", frame_acc, 32'd2);
        #1 rst_ = 1'b0;
        #1;
        chk("t5_trig_drop", {31'd0, bus.cmdTrigger}, 32'd0);
        chk("t5_busy_drop", {31'd0, busy}, 32'd0);
        sb.delete();
        repeat (2) tick();
        rst_ = 1'b1;
        repeat (2) tick();
        chk("t5_no_done", done_cnt - d0, 32'd0);
        chk("t5_pops",    frame_pop, 32'd3);
        chk("t5_level",   {25'd0, level}, 32'd1);
        preload(12'hC05, 3);
        push_frame(12'hC04);
        pulse_start();
        wait_done("t5_restart_done", 30, 1'b0);
        chk("t5_restart_acc", frame_acc, 32'd4);

        // Frame 6: six pixels queued, only four consumed per frame.
        preload(12'hD01, 6);
        push_frame(12'hD01);
        pulse_start();
        wait_done("t6_done", 30, 1'b0);
        tick();
        chk("t6_pops",  frame_pop, 32'd4);
        chk("t6_level", {25'd0, level}, 32'd2);
        preload(12'hD07, 2);
        push_frame(12'hD05);
        pulse_start();
        wait_done("t6_next_done", 30, 1'b0);
        tick();
        chk("t6_next_acc",   frame_acc, 32'd4);
        chk("t6_next_level", {25'd0, level}, 32'd0);
        chk("t6_cmdwrite",   {31'd0, bus.cmdWrite}, 32'd1);
        chk("sb_empty",      sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pix_sdram_writer

// File: doc/pix_sdram_writer.md
PIX_SDRAM_WRITER -- requirements
Module: pix_sdram_writer

Interface
REQ-001 SHALL have parameter AddrWidth, 23, SDRAM word-address width.
REQ-002 SHALL have parameter DataWidth, 16, SDRAM word width.
REQ-003 SHALL have parameter PixelWidth, 12, pixel width.
REQ-004 SHALL have parameter PixelCount, 2985984, pixels per frame (2304x1296).
REQ-005 SHALL have parameter BaseAddr, 0, first word address of the frame.
REQ-006 SHALL have port clk  in  1  single clock (SDRAM controller clock).
REQ-007 SHALL have port rst_  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  in  1  one-cycle pulse that arms capture of one frame.
REQ-009 SHALL have port fifo_q  in  PixelWidth  pixel at the pixel-FIFO head.
REQ-010 SHALL have port fifo_qValid  in  1  fifo_q holds a valid pixel.
REQ-011 SHALL have port fifo_qout  out  1  pop request; the FIFO head advances on the next edge.
REQ-012 SHALL have port cmdReady  in  1  SDRAM controller accepts the presented command.
REQ-013 SHALL have port cmdTrigger  out  1  command valid.
REQ-014 SHALL have port cmdAddr  out  AddrWidth  write address.
REQ-015 SHALL have port cmdWrite  out  1  write select.
REQ-016 SHALL have port cmdWriteData  out  DataWidth  write data.
REQ-017 SHALL have port busy  out  1  a frame is in progress.
REQ-018 SHALL have port done  out  1  one-cycle pulse after the last word of the frame is accepted.

Function
REQ-019 SHALL implement states Idle, Write and Drain; reset enters Idle.
REQ-020 Idle: on start=1, SHALL load the pixel counter with 0 and the address with BaseAddr, and enter Write.
REQ-021 Idle: fifo_qout SHALL be 0, so pixels stay queued until start.
REQ-022 Write: fifo_qout SHALL equal fifo_qValid && (!cmdTrigger || cmdReady) && (popped < PixelCount).
REQ-023 On a pop, cmdWriteData SHALL be loaded with fifo_q zero-extended to DataWidth (bits 15:12 = 0).
REQ-024 On a pop, cmdTrigger SHALL be set to 1; each pop SHALL have exactly one cycle of latency to cmdTrigger.
REQ-025 A command SHALL be accepted on the edge where cmdTrigger && cmdReady.
REQ-026 On acceptance, cmdAddr SHALL increment by 1; cmdTrigger SHALL clear unless a new pop occurs on the same edge.
REQ-027 While cmdTrigger=1 && cmdReady=0, cmdAddr, cmdWriteData and cmdTrigger SHALL stay stable.
REQ-028 Acceptance and a new pop on the same edge SHALL give back-to-back writes at 1 word per cycle.
REQ-029 After the PixelCount-th pop, the block SHALL enter Drain.
REQ-030 Drain: fifo_qout SHALL be 0; when the final word is accepted, done SHALL pulse for exactly 1 cycle, and the block SHALL enter Idle.
REQ-031 cmdWrite SHALL be constantly 1.
REQ-032 busy SHALL be 1 in Write and Drain, else 0.
REQ-033 start during Write or Drain SHALL be ignored; it SHALL have no effect on the counter or address.
REQ-034 The pixel counter SHALL be ceil(log2(PixelCount+1)) bits wide.
REQ-035 cmdAddr SHALL never exceed BaseAddr+PixelCount-1.
REQ-036 Elaboration SHALL fail if BaseAddr+PixelCount > 2^AddrWidth, so address wrap is impossible.
REQ-037 fifo_qValid=0 in Write SHALL stall the block: no pop, and no state change.

Reset
REQ-038 Reset SHALL set: state=Idle, cmdTrigger=0, cmdAddr=0, cmdWriteData=0, cmdWrite=1, fifo_qout=0, busy=0, done=0, counter=0.
REQ-039 Reset asserted mid-frame SHALL abort the frame; a pending command SHALL be dropped and no done SHALL be emitted.
REQ-040 Reset assertion SHALL take effect asynchronously; deassertion SHALL be synchronised externally to clk.

Structure
REQ-041 AddrWidth, DataWidth, PixelWidth and the state enum SHALL live in a shared package used with the SDRAM controller top.
REQ-042 The block SHALL be a single module with no sub-module; the command holding register is inline.

Verification (PixelCount=4, BaseAddr=0x100)
REQ-043 Bench: FIFO preloaded with 0xA01..0xA04, cmdReady=1, start pulse -> 4 writes on consecutive cycles, addresses 0x100..0x103, data 0x0A01..0x0A04, then done 1 cycle after the last acceptance, then busy=0.
REQ-044 Bench: cmdReady=0 for 3 cycles while cmdTrigger=1 -> cmdAddr and cmdWriteData hold, no pop, and the write completes when cmdReady=1.
REQ-045 Bench: fifo_qValid toggling every other cycle -> exactly 4 writes, no duplicates and no skips; pop count=4.
REQ-046 Bench: start re-pulsed mid-frame -> ignored, addresses continue sequentially, single done.
REQ-047 Bench: rst_ low after the 2nd write -> cmdTrigger=0 immediately, no done; next start restarts at 0x100.
REQ-048 Bench: FIFO holds 6 pixels -> only 4 are popped; 2 remain for the next frame, which starts at 0x100 with pixel 5.
